// File: rtl/clksel_if.sv
// Request/status bundle between the CPU/config side and the clock-select sequencer.
interface clksel_if;
    logic       wr_stb;
    logic [1:0] req_sel;
    logic [1:0] clksel;
    logic       busy;
    logic       chg_done;
    logic [7:0] chg_cnt;

    modport master (
        output wr_stb, req_sel,
        input  clksel, busy, chg_done, chg_cnt
    );

    modport slave (
        input  wr_stb, req_sel,
        output clksel, busy, chg_done, chg_cnt
    );
endinterface

// File: rtl/clksel_sequencer.sv
// Applies clock-mode requests to the switcher one at a time, holding clksel stable
// for SETTLE_CYC cycles after each change so the glitch-free handover can complete.
module clksel_sequencer #(
    parameter int unsigned SETTLE_CYC = 32,
    parameter logic [1:0]  RST_SEL    = 2'b00
) (
    input logic     clk,
    input logic     rst,
    clksel_if.slave bus
);

    typedef enum logic {IDLE, SETTLE} state_t;

    localparam logic [7:0] RELOAD = 8'(SETTLE_CYC - 1);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic       pend_vld, pend_vld_n;
    logic [1:0] pend_sel, pend_sel_n;
    logic [1:0] sel, sel_n;
    logic [7:0] chg_cnt, chg_cnt_n;
    logic       busy, busy_n;
    logic       done, done_n;
    logic       eff_vld;
    logic [1:0] eff_sel;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        pend_vld_n = pend_vld;
        pend_sel_n = pend_sel;
        sel_n      = sel;
        chg_cnt_n  = chg_cnt;
        done_n     = 1'b0;
        eff_vld    = 1'b0;
        eff_sel    = pend_sel;

        case (state)
            IDLE: begin
                if (bus.wr_stb && (bus.req_sel != sel)) begin
                    sel_n     = bus.req_sel;
                    chg_cnt_n = sat_inc(chg_cnt);
                    cnt_n     = RELOAD;
                    state_n   = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == 8'd0) begin
                    // A write landing on the expiry edge overrides whatever was stored.
                    eff_vld    = bus.wr_stb ? (bus.req_sel != sel) : pend_vld;
                    eff_sel    = bus.wr_stb ? bus.req_sel : pend_sel;
                    pend_vld_n = 1'b0;
                    if (eff_vld) begin
                        sel_n     = eff_sel;
                        chg_cnt_n = sat_inc(chg_cnt);
                        cnt_n     = RELOAD;
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end else begin
                    cnt_n = cnt - 8'd1;
                    if (bus.wr_stb) begin
                        pend_sel_n = bus.req_sel;
                        pend_vld_n = (bus.req_sel != sel);
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n == SETTLE) | pend_vld_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            pend_vld <= 1'b0;
            sel      <= RST_SEL;
            chg_cnt  <= 8'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            pend_vld <= pend_vld_n;
            sel      <= sel_n;
            chg_cnt  <= chg_cnt_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    // pend_sel is only meaningful while pend_vld is set, so it needs no reset.
    always_ff @(posedge clk) begin
        pend_sel <= pend_sel_n;
    end

    assign bus.clksel   = sel;
    assign bus.busy     = busy;
    assign bus.chg_done = done;
    assign bus.chg_cnt  = chg_cnt;

endmodule

// File: tb/tb_clksel_sequencer.sv
// Bench for clksel_sequencer with a 4-cycle settle window: directed scenarios plus a
// randomized run scored against a cycle model.
module tb_clksel_sequencer;

    localparam int SETTLE = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    clksel_if bus ();

    clksel_sequencer #(.SETTLE_CYC(SETTLE), .RST_SEL(2'b00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sel;
        logic       busy;
        logic       done;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    // Cycle model state
    logic [1:0] m_sel;
    logic       m_settle;
    int         m_rem;
    logic       m_pv;
    logic [1:0] m_ps;
    logic       m_done;
    logic [7:0] m_cnt;
    int         m_total;

    task automatic model_reset();
        m_sel = 2'b00; m_settle = 1'b0; m_rem = 0; m_pv = 1'b0; m_ps = 2'b00;
        m_done = 1'b0; m_cnt = 8'd0;
    endtask

    task automatic model_apply(input logic [1:0] s);
        m_sel   = s;
        m_total = m_total + 1;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        m_settle = 1'b1;
        m_rem    = SETTLE - 1;
    endtask

    task automatic model_edge(input logic w, input logic [1:0] s);
        logic       want;
        logic [1:0] target;
        m_done = 1'b0;
        if (!m_settle) begin
            if (w && s != m_sel) model_apply(s);
        end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
            if (w) begin m_ps = s; m_pv = (s != m_sel); end
        end else begin
            want   = w ? (s != m_sel) : m_pv;
            target = w ? s : m_ps;
            m_pv   = 1'b0;
            if (want) model_apply(target);
            else begin m_settle = 1'b0; m_done = 1'b1; end
        end
    endtask

    task automatic step(input logic w, input logic [1:0] s);
        bus.wr_stb  = w;
        bus.req_sel = s;
        @(posedge clk);
        #1;
        bus.wr_stb = 1'b0;
    endtask

    task automatic do_reset();
        bus.wr_stb = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int moved;
        rst = 1'b1;
        repeat (2) step(1'b1, 2'b11);
        rst = 1'b0;
        checks++;
        if (bus.clksel !== 2'b00 || bus.busy !== 1'b0 || bus.chg_done !== 1'b0 || bus.chg_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_state got sel=%b busy=%b done=%b cnt=%0d want sel=00 busy=0 done=0 cnt=0",
                     bus.clksel, bus.busy, bus.chg_done, bus.chg_cnt);
        end
        moved = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 2'b00);
            if (bus.clksel !== 2'b00 || bus.busy !== 1'b0) moved++;
        end
        checks++;
        if (moved != 0) begin
            errors++;
            $display("FAIL reset_idle_hold got %0d disturbed cycles want 0", moved);
        end
    endtask

    task automatic test_single();
        int bad;
        do_reset();
        step(1'b1, 2'b10);
        checks++;
        if (bus.clksel !== 2'b10 || bus.busy !== 1'b1 || bus.chg_cnt !== 8'd1 || bus.chg_done !== 1'b0) begin
            errors++;
            $display("FAIL single_apply got sel=%b busy=%b cnt=%0d done=%b want sel=10 busy=1 cnt=1 done=0",
                     bus.clksel, bus.busy, bus.chg_cnt, bus.chg_done);
        end
        bad = 0;
        for (int i = 1; i < SETTLE; i++) begin
            step(1'b0, 2'b00);
            if (bus.busy !== 1'b1 || bus.chg_done !== 1'b0 || bus.clksel !== 2'b10) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL single_window got %0d bad cycles want 0", bad);
        end
        step(1'b0, 2'b00);
        checks++;
        if (bus.chg_done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done got done=%b busy=%b want done=1 busy=0", bus.chg_done, bus.busy);
        end
        step(1'b0, 2'b00);
        checks++;
        if (bus.chg_done !== 1'b0) begin
            errors++;
            $display("FAIL single_done_width got done=%b want 0", bus.chg_done);
        end
        step(1'b1, 2'b10);
        checks++;
        if (bus.busy !== 1'b0 || bus.chg_cnt !== 8'd1 || bus.chg_done !== 1'b0) begin
            errors++;
            $display("FAIL same_sel_noop got busy=%b cnt=%0d done=%b want busy=0 cnt=1 done=0",
                     bus.busy, bus.chg_cnt, bus.chg_done);
        end
    endtask

    task automatic test_pending();
        int dones;
        do_reset();
        step(1'b1, 2'b10);
        step(1'b1, 2'b01);
        step(1'b1, 2'b11);
        step(1'b0, 2'b00);
        checks++;
        if (bus.clksel !== 2'b10) begin
            errors++;
            $display("FAIL pend_hold got sel=%b want 10", bus.clksel);
        end
        step(1'b0, 2'b00);
        checks++;
        if (bus.clksel !== 2'b11 || bus.chg_cnt !== 8'd2 || bus.chg_done !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL pend_apply got sel=%b cnt=%0d done=%b busy=%b want sel=11 cnt=2 done=0 busy=1",
                     bus.clksel, bus.chg_cnt, bus.chg_done, bus.busy);
        end
        dones = 0;
        for (int i = 0; i < SETTLE; i++) begin
            step(1'b0, 2'b00);
            if (bus.chg_done === 1'b1) dones++;
        end
        checks++;
        if (dones != 1 || bus.chg_done !== 1'b1 || bus.busy !== 1'b0 || bus.clksel !== 2'b11) begin
            errors++;
            $display("FAIL pend_done got dones=%0d last_done=%b busy=%b sel=%b want 1 1 0 11",
                     dones, bus.chg_done, bus.busy, bus.clksel);
        end
    endtask

    task automatic test_cancel();
        do_reset();
        step(1'b1, 2'b10);
        step(1'b1, 2'b01);
        step(1'b1, 2'b10);
        step(1'b0, 2'b00);
        step(1'b0, 2'b00);
        checks++;
        if (bus.chg_done !== 1'b1 || bus.clksel !== 2'b10 || bus.chg_cnt !== 8'd1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL cancel got done=%b sel=%b cnt=%0d busy=%b want done=1 sel=10 cnt=1 busy=0",
                     bus.chg_done, bus.clksel, bus.chg_cnt, bus.busy);
        end
    endtask

    task automatic test_expiry_write();
        int dones;
        do_reset();
        step(1'b1, 2'b10);
        repeat (SETTLE - 1) step(1'b0, 2'b00);
        step(1'b1, 2'b01);
        checks++;
        if (bus.clksel !== 2'b01 || bus.chg_done !== 1'b0 || bus.busy !== 1'b1 || bus.chg_cnt !== 8'd2) begin
            errors++;
            $display("FAIL expiry_write got sel=%b done=%b busy=%b cnt=%0d want sel=01 done=0 busy=1 cnt=2",
                     bus.clksel, bus.chg_done, bus.busy, bus.chg_cnt);
        end
        dones = 0;
        for (int i = 0; i < SETTLE; i++) begin
            step(1'b0, 2'b00);
            if (bus.chg_done === 1'b1) dones++;
        end
        checks++;
        if (dones != 1 || bus.chg_done !== 1'b1) begin
            errors++;
            $display("FAIL expiry_done got dones=%0d last=%b want 1 1", dones, bus.chg_done);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        do_reset();
        step(1'b1, 2'b10);
        step(1'b0, 2'b00);
        rst = 1'b1;
        step(1'b0, 2'b00);
        rst = 1'b0;
        checks++;
        if (bus.clksel !== 2'b00 || bus.busy !== 1'b0 || bus.chg_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid got sel=%b busy=%b cnt=%0d want sel=00 busy=0 cnt=0",
                     bus.clksel, bus.busy, bus.chg_cnt);
        end
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 2'b00);
            if (bus.chg_done === 1'b1 || bus.busy === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet got %0d active cycles want 0", dones);
        end
    endtask

    task automatic test_random();
        exp_t       e;
        logic       w;
        logic [1:0] s;
        logic [1:0] prev_sel;
        int         cyc, last_chg, mm;
        do_reset();
        model_reset();
        m_total  = 0;
        cyc      = 0;
        last_chg = -SETTLE;
        prev_sel = bus.clksel;
        mm       = 0;
        while (m_total < 300 && cyc < 20000) begin
            w = ($urandom_range(0, 3) != 0);
            s = 2'($urandom_range(0, 3));
            model_edge(w, s);
            exp_q.push_back('{sel: m_sel, busy: (m_settle | m_pv), done: m_done, cnt: m_cnt});
            step(w, s);
            cyc++;
            e = exp_q.pop_front();
            checks++;
            if (bus.clksel !== e.sel || bus.busy !== e.busy || bus.chg_done !== e.done || bus.chg_cnt !== e.cnt) begin
                errors++;
                if (mm < 5)
                    $display("FAIL rand_cycle%0d got sel=%b busy=%b done=%b cnt=%0d want sel=%b busy=%b done=%b cnt=%0d",
                             cyc, bus.clksel, bus.busy, bus.chg_done, bus.chg_cnt, e.sel, e.busy, e.done, e.cnt);
                mm++;
            end
            if (bus.clksel !== prev_sel) begin
                checks++;
                if (cyc - last_chg < SETTLE) begin
                    errors++;
                    $display("FAIL min_hold got %0d cycles want >= %0d", cyc - last_chg, SETTLE);
                end
                last_chg = cyc;
                prev_sel = bus.clksel;
            end
        end
        checks++;
        if (m_total < 300) begin
            errors++;
            $display("FAIL rand_budget got %0d changes want 300", m_total);
        end
        checks++;
        if (bus.chg_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL saturate got %0d want 255", bus.chg_cnt);
        end
    endtask

    initial begin
        bus.wr_stb  = 1'b0;
        bus.req_sel = 2'b00;
        test_reset();
        test_single();
        test_pending();
        test_cancel();
        test_expiry_write();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
